tt_alu_iter: RTL

Parametrised, handshaked successor to the team's 4-bit opcode ALU. It supports operand width `WIDTH`, the same nine-operation opcode set, and iterative multi-cycle multiply and divide. Operations are accepted over a valid/ready input channel and delivered over a valid/ready output channel with registered flags. The block sits between the tile's input-capture logic and the output mux, and is the arithmetic core for wider datapath variants.

---
 rtl/tt_alu_pkg.sv | 20 ++
 rtl/tt_alu_iter_muldiv.sv | 55 +++++
 rtl/tt_alu_iter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tt_alu_pkg.sv
// tt_alu_pkg: opcode and FSM state encodings plus the default ENC key.
package tt_alu_pkg;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_NOT = 4'd7,
        OP_ENC = 4'd8
    } op_e;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
    localparam logic [15:0] DEFAULT_KEY = 16'hABAB;
endpackage

// File: rtl/tt_alu_iter_muldiv.sv
// tt_alu_iter_muldiv: shared shift-add multiplier / restoring divider, one bit per cycle.
module tt_alu_iter_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_result
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_div;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rs;
    logic [WIDTH-1:0]   w_df;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_next;
    // acc = {hi, multiplier} for MUL, {remainder, dividend/quotient} for DIV
    always_comb begin
        w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{r_acc[0]}} & r_b};
        w_rs     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_ge     = w_rs >= {1'b0, r_b};
        w_df     = w_rs[WIDTH-1:0] - r_b;
        w_next   = r_div ? {w_ge ? w_df : w_rs[WIDTH-1:0], r_acc[WIDTH-2:0], w_ge}
                         : {w_sum, r_acc[WIDTH-1:1]};
        o_done   = r_busy && (r_cnt == CW'(WIDTH - 1));
        o_result = r_div ? {w_next[WIDTH-1:0], w_next[2*WIDTH-1:WIDTH]} : w_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_div  <= 1'b0;
        end else if (i_start) begin
            r_acc  <= {{WIDTH{1'b0}}, i_a};
            r_b    <= i_b;
            r_div  <= i_div;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc  <= w_next;
            r_cnt  <= r_cnt + CW'(1);
            r_busy <= !o_done;
        end
    end
endmodule

// File: rtl/tt_alu_iter.sv
// tt_alu_iter: handshaked ALU with single-cycle logic ops and iterative MUL/DIV.
module tt_alu_iter
    import tt_alu_pkg::*;
#(
    parameter int                 WIDTH = 8,
    parameter logic [2*WIDTH-1:0] KEY   = (2*WIDTH)'(DEFAULT_KEY)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [3:0]         i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [2*WIDTH-1:0] o_result,
    output logic               o_carry,
    output logic               o_overflow,
    output logic               o_div_by_zero,
    output logic               o_illegal_op,
    output logic               o_zero
);
    state_e             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [2*WIDTH-1:0] r_result;
    logic               r_carry, r_overflow, r_dbz, r_illegal, r_zero, r_is_mul;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_dif;
    logic [2*WIDTH-1:0] w_res;
    logic               w_c, w_ov, w_dz, w_il;
    logic               w_accept, w_iter, w_md_done;
    logic [2*WIDTH-1:0] w_md_res;
    always_comb begin
        w_accept = i_in_valid && r_in_ready;
        w_iter   = (i_op == OP_MUL) || (i_op == OP_DIV && |i_b);
        w_sum    = {1'b0, i_a} + {1'b0, i_b};
        w_dif    = i_a - i_b;
        w_res    = '0;
        w_c      = 1'b0;
        w_ov     = 1'b0;
        w_dz     = 1'b0;
        w_il     = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_res = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
                w_c   = w_sum[WIDTH];
                w_ov  = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = {{WIDTH{1'b0}}, w_dif};
                w_c   = i_a < i_b;
                w_ov  = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_dif[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_MUL: ;
            OP_DIV: begin
                w_res = {{WIDTH{1'b1}}, i_a};
                w_dz  = 1'b1;
            end
            OP_AND:  w_res = {{WIDTH{1'b0}}, i_a & i_b};
            OP_OR:   w_res = {{WIDTH{1'b0}}, i_a | i_b};
            OP_XOR:  w_res = {{WIDTH{1'b0}}, i_a ^ i_b};
            OP_NOT:  w_res = {{WIDTH{1'b0}}, ~i_a};
            OP_ENC:  w_res = {i_a, i_b} ^ KEY;
            default: w_il  = 1'b1;
        endcase
    end
    tt_alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept && w_iter),
        .i_div    (i_op == OP_DIV),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_done   (w_md_done),
        .o_result (w_md_res)
    );
    // in_ready is a register so it reads 0 throughout reset despite the IDLE reset state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_dbz       <= 1'b0;
            r_illegal   <= 1'b0;
            r_zero      <= 1'b0;
            r_is_mul    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_is_mul   <= i_op == OP_MUL;
                        if (w_iter) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_carry     <= w_c;
                            r_overflow  <= w_ov;
                            r_dbz       <= w_dz;
                            r_illegal   <= w_il;
                            r_zero      <= w_res == '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_md_done) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_md_res;
                        r_carry     <= 1'b0;
                        r_overflow  <= r_is_mul && |w_md_res[2*WIDTH-1:WIDTH];
                        r_dbz       <= 1'b0;
                        r_illegal   <= 1'b0;
                        r_zero      <= w_md_res == '0;
                    end
                end
                default: begin
                    if (i_out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end
    assign o_in_ready    = r_in_ready;
    assign o_out_valid   = r_out_valid;
    assign o_result      = r_result;
    assign o_carry       = r_carry;
    assign o_overflow    = r_overflow;
    assign o_div_by_zero = r_dbz;
    assign o_illegal_op  = r_illegal;
    assign o_zero        = r_zero;
endmodule
